// File: rtl/btb_pkg.sv
// ---------------------------------------------------------------------------
// btb_pkg
// Shared types, constants and helpers for the 2-way branch target buffer.
//  - btb_entry_t : one BTB entry {valid, tag, cnt, target} at default widths
//  - CNT_WNT/CNT_WT : weakly-not-taken / weakly-taken counter values (CNT_W=2)
//  - sat_update  : saturating up/down counter step for any CNT_W <= CNT_MAX_W
// ---------------------------------------------------------------------------
package btb_pkg;

    localparam int PC_W_DEF  = 32;
    localparam int TAG_W_DEF = 8;
    localparam int CNT_W_DEF = 2;
    localparam int CNT_MAX_W = 8;

    localparam logic [CNT_W_DEF-1:0] CNT_WNT = 2'b01;
    localparam logic [CNT_W_DEF-1:0] CNT_WT  = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [TAG_W_DEF-1:0]  tag;
        logic [CNT_W_DEF-1:0]  cnt;
        logic [PC_W_DEF-1:0]   target;
    } btb_entry_t;

    // Saturating counter step; cnt_w is the live counter width, upper bits are zero.
    function automatic logic [CNT_MAX_W-1:0] sat_update(
        input logic [CNT_MAX_W-1:0] cnt,
        input logic                 taken,
        input int                   cnt_w
    );
        logic [CNT_MAX_W-1:0] cnt_max;
        logic [CNT_MAX_W-1:0] res;
        cnt_max = CNT_MAX_W'((32'd1 << cnt_w) - 32'd1);
        if (taken) begin
            if (cnt >= cnt_max) res = cnt_max;
            else                res = cnt + CNT_MAX_W'(32'd1);
        end else begin
            if (cnt == CNT_MAX_W'(32'd0)) res = cnt;
            else                          res = cnt - CNT_MAX_W'(32'd1);
        end
        return res;
    endfunction

endpackage

// File: rtl/btb_2way_predictor_if.sv
// ---------------------------------------------------------------------------
// btb_2way_predictor_if
// Fetch-lookup and EX-update bundle between the pipeline and the BTB.
//  master (pipeline): drives pc_if_i, upd_valid_i, upd_pc_i, upd_taken_i,
//                     upd_target_i; receives hit_o, taken_o, target_o
//  slave  (BTB)     : the mirror image
// ---------------------------------------------------------------------------
interface btb_2way_predictor_if #(
    parameter int PC_W = 32
);
    import btb_pkg::*;

    logic [PC_W-1:0] pc_if_i;
    logic            hit_o;
    logic            taken_o;
    logic [PC_W-1:0] target_o;
    logic            upd_valid_i;
    logic [PC_W-1:0] upd_pc_i;
    logic            upd_taken_i;
    logic [PC_W-1:0] upd_target_i;

    modport master (
        output pc_if_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
        input  hit_o, taken_o, target_o
    );

    modport slave (
        input  pc_if_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
        output hit_o, taken_o, target_o
    );

endinterface

// File: rtl/btb_way_cmp.sv
// ---------------------------------------------------------------------------
// btb_way_cmp
// Combinational tag compare for one 2-way set, plus hit-way and victim-way pick.
//  i_valid[1:0]  valid bits of way 1/0      i_tag0/i_tag1  stored tags
//  i_tag         tag being looked up         i_lru          LRU way of the set
//  o_hit         some valid way matches      o_hit_way      matching way (way 0 wins)
//  o_victim_way  first invalid way (way 0 preferred), else the LRU way
// ---------------------------------------------------------------------------
module btb_way_cmp
    import btb_pkg::*;
#(
    parameter int TAG_W = 8
) (
    input  logic [1:0]       i_valid,
    input  logic [TAG_W-1:0] i_tag0,
    input  logic [TAG_W-1:0] i_tag1,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_lru,
    output logic             o_hit,
    output logic             o_hit_way,
    output logic             o_victim_way
);

    logic w_m0;
    logic w_m1;

    // Per-way match, hit-way priority and victim selection.
    always_comb begin
        w_m0  = i_valid[0] && (i_tag0 == i_tag);
        w_m1  = i_valid[1] && (i_tag1 == i_tag);
        o_hit = w_m0 | w_m1;
        if (w_m0)      o_hit_way = 1'b0;
        else if (w_m1) o_hit_way = 1'b1;
        else           o_hit_way = 1'b0;
        if (!i_valid[0])      o_victim_way = 1'b0;
        else if (!i_valid[1]) o_victim_way = 1'b1;
        else                  o_victim_way = i_lru;
    end

endmodule

// File: rtl/btb_2way_predictor.sv
// ---------------------------------------------------------------------------
// btb_2way_predictor
// 2-way set-associative BTB with per-entry saturating direction counters and
// per-set LRU. Lookup is combinational on the fetch PC; updates from EX pass
// through one register stage and are written into the array on the next edge.
//  clk_i   clock (rising edge)          rst_i   synchronous reset, active-high
//  clear_i invalidate all entries and drop the update held in the register stage
//  bus     btb_2way_predictor_if.slave: pc_if_i -> hit_o/taken_o/target_o,
//          upd_valid_i/upd_pc_i/upd_taken_i/upd_target_i
// ---------------------------------------------------------------------------
module btb_2way_predictor
    import btb_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int NUM_SETS = 128,
    parameter int TAG_W    = TAG_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    btb_2way_predictor_if.slave   bus
);

    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_HI = IDX_W + TAG_W + 1;
    localparam logic [CNT_W-1:0] L_CNT_WNT = CNT_W'((32'd1 << (CNT_W - 1)) - 32'd1);
    localparam logic [CNT_W-1:0] L_CNT_WT  = CNT_W'(32'd1 << (CNT_W - 1));

    // Array state: valid/LRU need single-cycle clear, the rest are plain flop arrays.
    logic [1:0]          r_valid [NUM_SETS];
    logic [TAG_W-1:0]    r_tag   [NUM_SETS][2];
    logic [CNT_W-1:0]    r_cnt   [NUM_SETS][2];
    logic [PC_W-1:0]     r_tgt   [NUM_SETS][2];
    logic [NUM_SETS-1:0] r_lru;

    // Update register stage.
    logic            r_upd_vld;
    logic [PC_W-1:0] r_upd_pc;
    logic            r_upd_taken;
    logic [PC_W-1:0] r_upd_tgt;

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic             w_lk_way;
    logic             w_lk_victim_unused;

    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic             w_up_way;
    logic             w_up_victim;
    logic [CNT_W-1:0] w_up_cnt_next;
    logic             w_pc_unused;

    assign w_lk_idx = bus.pc_if_i[IDX_W+1:2];
    assign w_lk_tag = bus.pc_if_i[TAG_HI:IDX_W+2];
    assign w_up_idx = r_upd_pc[IDX_W+1:2];
    assign w_up_tag = r_upd_pc[TAG_HI:IDX_W+2];

    // Byte-offset bits and bits above the tag take no part in indexing or matching.
    assign w_pc_unused = ^{bus.pc_if_i[1:0], bus.pc_if_i[PC_W-1:TAG_HI+1],
                           r_upd_pc[1:0], r_upd_pc[PC_W-1:TAG_HI+1]};

    btb_way_cmp #(.TAG_W(TAG_W)) u_lk_cmp (
        .i_valid      (r_valid[w_lk_idx]),
        .i_tag0       (r_tag[w_lk_idx][0]),
        .i_tag1       (r_tag[w_lk_idx][1]),
        .i_tag        (w_lk_tag),
        .i_lru        (r_lru[w_lk_idx]),
        .o_hit        (w_lk_hit),
        .o_hit_way    (w_lk_way),
        .o_victim_way (w_lk_victim_unused)
    );

    // The update compare reads the array as it stands when the registered update is
    // applied, so back-to-back updates to one set see each other's effect.
    btb_way_cmp #(.TAG_W(TAG_W)) u_up_cmp (
        .i_valid      (r_valid[w_up_idx]),
        .i_tag0       (r_tag[w_up_idx][0]),
        .i_tag1       (r_tag[w_up_idx][1]),
        .i_tag        (w_up_tag),
        .i_lru        (r_lru[w_up_idx]),
        .o_hit        (w_up_hit),
        .o_hit_way    (w_up_way),
        .o_victim_way (w_up_victim)
    );

    assign w_up_cnt_next = CNT_W'(sat_update(CNT_MAX_W'(r_cnt[w_up_idx][w_up_way]),
                                             r_upd_taken, CNT_W));

    // Lookup outputs straight from the array; no forwarding from the update path.
    always_comb begin
        bus.hit_o    = w_lk_hit;
        bus.taken_o  = 1'b0;
        bus.target_o = {PC_W{1'b0}};
        if (w_lk_hit) begin
            bus.taken_o  = r_cnt[w_lk_idx][w_lk_way][CNT_W-1];
            bus.target_o = r_tgt[w_lk_idx][w_lk_way];
        end else begin
            bus.taken_o  = 1'b0;
            bus.target_o = {PC_W{1'b0}};
        end
    end

    // Update register stage: capture the resolved branch from EX.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_upd_vld   <= 1'b0;
            r_upd_pc    <= {PC_W{1'b0}};
            r_upd_taken <= 1'b0;
            r_upd_tgt   <= {PC_W{1'b0}};
        end else begin
            r_upd_vld <= bus.upd_valid_i;
            if (bus.upd_valid_i) begin
                r_upd_pc    <= bus.upd_pc_i;
                r_upd_taken <= bus.upd_taken_i;
                r_upd_tgt   <= bus.upd_target_i;
            end
        end
    end

    // Array write: reset, then clear (drops the registered update), then the update itself.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lru <= {NUM_SETS{1'b0}};
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= 2'b00;
                for (int w = 0; w < 2; w++) begin
                    r_tag[s][w] <= {TAG_W{1'b0}};
                    r_cnt[s][w] <= L_CNT_WNT;
                    r_tgt[s][w] <= {PC_W{1'b0}};
                end
            end
        end else if (clear_i) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= 2'b00;
            end
        end else if (r_upd_vld) begin
            if (w_up_hit) begin
                r_cnt[w_up_idx][w_up_way] <= w_up_cnt_next;
                if (r_upd_taken) begin
                    r_tgt[w_up_idx][w_up_way] <= r_upd_tgt;
                end
                r_lru[w_up_idx] <= ~w_up_way;
            end else if (r_upd_taken) begin
                r_valid[w_up_idx][w_up_victim] <= 1'b1;
                r_tag[w_up_idx][w_up_victim]   <= w_up_tag;
                r_tgt[w_up_idx][w_up_victim]   <= r_upd_tgt;
                r_cnt[w_up_idx][w_up_victim]   <= L_CNT_WT;
                r_lru[w_up_idx]                <= ~w_up_victim;
            end
        end
    end

endmodule

// File: tb/tb_btb_2way_predictor.sv
// ---------------------------------------------------------------------------
// tb_btb_2way_predictor
// Directed scenarios followed by a randomized phase, all compared against a
// reference model that keeps each set as a recency-ordered list of entries
// (most recent first, at most two) with integer direction counters.
// ---------------------------------------------------------------------------
module tb_btb_2way_predictor;

    logic clk;
    logic rst;
    logic clear;

    btb_2way_predictor_if #(.PC_W(32)) bus ();

    btb_2way_predictor dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clear),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per set, m_n live entries ordered most-recent first.
    int          m_n   [128];
    logic [7:0]  m_tag [128][2];
    int          m_cnt [128][2];
    logic [31:0] m_tgt [128][2];

    // Update accepted from EX, waiting to reach the array.
    bit          p_v;
    logic [31:0] p_pc;
    bit          p_tk;
    logic [31:0] p_tg;

    function automatic void m_lookup(input logic [31:0] pc, output logic h,
                                     output logic t, output logic [31:0] tg);
        int idx;
        idx = int'(pc[8:2]);
        h = 1'b0; t = 1'b0; tg = 32'h0;
        for (int i = 0; i < m_n[idx]; i++) begin
            if (m_tag[idx][i] == pc[16:9]) begin
                h  = 1'b1;
                t  = (m_cnt[idx][i] >= 2);
                tg = m_tgt[idx][i];
            end
        end
    endfunction

    function automatic void m_apply(input logic [31:0] pc, input bit tk, input logic [31:0] tg);
        int idx;
        int f;
        int c;
        logic [7:0]  st;
        logic [31:0] sg;
        idx = int'(pc[8:2]);
        f = -1;
        for (int i = 0; i < m_n[idx]; i++)
            if (m_tag[idx][i] == pc[16:9]) f = i;
        if (f >= 0) begin
            c = m_cnt[idx][f];
            c = tk ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
            st = m_tag[idx][f];
            sg = tk ? tg : m_tgt[idx][f];
            if (f == 1) begin
                m_tag[idx][1] = m_tag[idx][0];
                m_cnt[idx][1] = m_cnt[idx][0];
                m_tgt[idx][1] = m_tgt[idx][0];
            end
            m_tag[idx][0] = st; m_cnt[idx][0] = c; m_tgt[idx][0] = sg;
        end else if (tk) begin
            m_tag[idx][1] = m_tag[idx][0];
            m_cnt[idx][1] = m_cnt[idx][0];
            m_tgt[idx][1] = m_tgt[idx][0];
            m_tag[idx][0] = pc[16:9]; m_cnt[idx][0] = 2; m_tgt[idx][0] = tg;
            if (m_n[idx] < 2) m_n[idx]++;
        end
    endfunction

    // What one rising edge does to the model, seen from the spec's update timing.
    function automatic void model_edge();
        if (rst) begin
            for (int s = 0; s < 128; s++) m_n[s] = 0;
            p_v = 1'b0;
        end else begin
            if (clear) begin
                for (int s = 0; s < 128; s++) m_n[s] = 0;
            end else if (p_v) begin
                m_apply(p_pc, p_tk, p_tg);
            end
            p_v = bus.upd_valid_i;
            if (bus.upd_valid_i) begin
                p_pc = bus.upd_pc_i; p_tk = bus.upd_taken_i; p_tg = bus.upd_target_i;
            end
        end
    endfunction

    task automatic kchk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", nm, got, exp);
        end
    endtask

    task automatic mcheck(input string nm);
        logic h, t;
        logic [31:0] tg;
        m_lookup(bus.pc_if_i, h, t, tg);
        kchk({nm, "_hit"},    {31'd0, bus.hit_o},   {31'd0, h});
        kchk({nm, "_taken"},  {31'd0, bus.taken_o}, {31'd0, t});
        kchk({nm, "_target"}, bus.target_o,         tg);
    endtask

    task automatic probe(input logic [31:0] pc);
        bus.pc_if_i = pc;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        model_edge();
        #1;
        bus.upd_valid_i = 1'b0;
        clear = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic drive_upd(input logic [31:0] pc, input bit tk, input logic [31:0] tg);
        bus.upd_valid_i  = 1'b1;
        bus.upd_pc_i     = pc;
        bus.upd_taken_i  = tk;
        bus.upd_target_i = tg;
    endtask

    function automatic logic [31:0] rpc();
        logic [31:0] r;
        r       = $urandom;
        r[16:9] = 8'($urandom_range(0, 3));
        r[8:2]  = 7'($urandom_range(0, 3));
        return r;
    endfunction

    logic [31:0] fill_pc [4];

    initial begin
        rst = 1'b1; clear = 1'b0;
        bus.pc_if_i = 32'h0; bus.upd_valid_i = 1'b0; bus.upd_pc_i = 32'h0;
        bus.upd_taken_i = 1'b0; bus.upd_target_i = 32'h0;
        p_v = 1'b0; p_pc = 32'h0; p_tk = 1'b0; p_tg = 32'h0;
        for (int s = 0; s < 128; s++) m_n[s] = 0;
        adv();

        // 1: empty after reset across every set
        for (int a = 0; a < 32'h200; a += 4) begin
            probe(32'(a));
            kchk("rst_hit",    {31'd0, bus.hit_o},   32'd0);
            kchk("rst_taken",  {31'd0, bus.taken_o}, 32'd0);
            kchk("rst_target", bus.target_o,         32'd0);
            adv();
        end

        // 2: taken update visible two edges later, not before
        drive_upd(32'h100, 1'b1, 32'h400);
        probe(32'h100); kchk("t2_hit_e0", {31'd0, bus.hit_o}, 32'd0); mcheck("t2_e0"); adv();
        probe(32'h100); kchk("t2_hit_e1", {31'd0, bus.hit_o}, 32'd0); mcheck("t2_e1"); adv();
        probe(32'h100);
        kchk("t2_hit",    {31'd0, bus.hit_o},   32'd1);
        kchk("t2_taken",  {31'd0, bus.taken_o}, 32'd1);
        kchk("t2_target", bus.target_o,         32'h400);
        adv();

        // 3: three not-taken updates saturate at zero; target kept
        for (int k = 0; k < 3; k++) begin
            drive_upd(32'h100, 1'b0, 32'hDEAD_0000); adv(); adv();
            probe(32'h100);
            kchk("t3_hit",    {31'd0, bus.hit_o},   32'd1);
            kchk("t3_taken",  {31'd0, bus.taken_o}, 32'd0);
            kchk("t3_target", bus.target_o,         32'h400);
            adv();
        end
        // from a saturated 00, one taken gives 01 (still not taken), a second gives 10
        drive_upd(32'h100, 1'b1, 32'h400); adv(); adv();
        probe(32'h100); kchk("t3_sat_taken1", {31'd0, bus.taken_o}, 32'd0); adv();
        drive_upd(32'h100, 1'b1, 32'h400); adv(); adv();
        probe(32'h100); kchk("t3_sat_taken2", {31'd0, bus.taken_o}, 32'd1); adv();

        // 4: three tags in set 0x40, back-to-back; the third evicts the LRU way (0x100)
        drive_upd(32'h0001_0100, 1'b1, 32'h1111_0000); adv();
        drive_upd(32'h0000_0300, 1'b1, 32'h3333_0000); adv(); adv();
        probe(32'h100);        kchk("t4_evicted", {31'd0, bus.hit_o}, 32'd0); mcheck("t4_a"); adv();
        probe(32'h0001_0100);  kchk("t4_b_hit", {31'd0, bus.hit_o}, 32'd1);
        kchk("t4_b_tgt", bus.target_o, 32'h1111_0000); adv();
        probe(32'h0000_0300);  kchk("t4_c_hit", {31'd0, bus.hit_o}, 32'd1);
        kchk("t4_c_tgt", bus.target_o, 32'h3333_0000); adv();

        // 5: not-taken miss allocates nothing
        drive_upd(32'h208, 1'b0, 32'h5000); adv(); adv();
        probe(32'h208); kchk("t5_noalloc", {31'd0, bus.hit_o}, 32'd0); adv();

        // 6: fill four entries, then clear while an update is in the register stage
        fill_pc[0] = 32'h1000; fill_pc[1] = 32'h2004; fill_pc[2] = 32'h3008; fill_pc[3] = 32'h400C;
        for (int i = 0; i < 4; i++) begin
            drive_upd(fill_pc[i], 1'b1, fill_pc[i] + 32'h8000); adv();
        end
        adv();
        for (int i = 0; i < 4; i++) begin
            probe(fill_pc[i]); kchk("t6_filled", {31'd0, bus.hit_o}, 32'd1); adv();
        end
        drive_upd(32'h500C, 1'b1, 32'h5555_0000); adv();
        clear = 1'b1;
        probe(32'h1000); mcheck("t6_preclear"); adv();
        for (int i = 0; i < 4; i++) begin
            probe(fill_pc[i]); kchk("t6_cleared", {31'd0, bus.hit_o}, 32'd0); adv();
        end
        probe(32'h500C); kchk("t6_dropped", {31'd0, bus.hit_o}, 32'd0); mcheck("t6_d"); adv();

        // Randomized traffic on a few sets/tags, with occasional clear and reset
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 99) < 55)
                drive_upd(rpc(), 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 99) < 2)  clear = 1'b1;
            if ($urandom_range(0, 299) < 1) rst = 1'b1;
            probe(rpc());
            mcheck("rnd");
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
